booth_mult: RTL and testbench

Sequential signed multiplier using radix-4 (modified) Booth recoding. It retires two multiplier bits per clock, so an A_WIDTH × B_WIDTH product takes ceil(B_WIDTH/2) cycles after a single-cycle load. It is a compact, area-oriented arithmetic unit for datapaths that can tolerate multi-cycle latency instead of a full array multiplier.

---
 rtl/booth_mult.sv | 120 ++++++++++++
 tb/tb_booth_mult.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult.sv
// Sequential signed multiplier, radix-4 (modified) Booth recoding.
// Retires two multiplier bits per clock; an A_WIDTH x B_WIDTH product is
// ready ceil(B_WIDTH/2) edges after the load edge.
// Optional feature: define BOOTH_MULT_DONE_EN to add the one-cycle `done` pulse.
module booth_mult #(
  parameter int unsigned A_WIDTH = 6,
  parameter int unsigned B_WIDTH = 6,
  parameter int unsigned P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  output logic [P_WIDTH-1:0] P
`ifdef BOOTH_MULT_DONE_EN
  ,
  output logic               done
`endif
);

  // Number of radix-4 digits; multiplier is sign-extended to an even width N2.
  localparam int unsigned Iter = (B_WIDTH + 1) / 2;
  localparam int unsigned N2   = 2 * Iter;
  localparam int unsigned CntW = (Iter > 1) ? $clog2(Iter) : 1;
  localparam int unsigned ShW  = CntW + 1;

  logic [P_WIDTH-1:0] m_q, m_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [P_WIDTH-1:0] p_q, p_d;
  logic [N2:0]        q_q, q_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [P_WIDTH-1:0] pp;
  logic [P_WIDTH-1:0] pp_sh;
  logic [ShW-1:0]     sh_amt;
  logic               last_iter;

  // Booth digit recode of the low triplet, weighted by 4^counter.
  always_comb begin
    unique case (q_q[2:0])
      3'b001, 3'b010: pp = m_q;
      3'b011:         pp = m_q << 1;
      3'b100:         pp = -(m_q << 1);
      3'b101, 3'b110: pp = -m_q;
      default:        pp = '0;
    endcase
    sh_amt    = {cnt_q, 1'b0};
    pp_sh     = pp << sh_amt;
    last_iter = busy_q && (cnt_q == CntW'(Iter - 1));
  end

  // Next state: load restarts (and wins over a finishing iteration); else iterate.
  always_comb begin
    m_d    = m_q;
    q_d    = q_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    p_d    = p_q;
    if (load) begin
      m_d    = P_WIDTH'($signed(A));
      q_d    = {N2'($signed(B)), 1'b0};
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_q + pp_sh;
      q_d   = {{2{q_q[N2]}}, q_q[N2:2]};
      cnt_d = cnt_q + 1'b1;
      if (last_iter) begin
        p_d    = acc_d;
        busy_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      q_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      p_q    <= '0;
    end else begin
      m_q    <= m_d;
      q_q    <= q_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      p_q    <= p_d;
    end
  end

  assign P = p_q;

`ifdef BOOTH_MULT_DONE_EN
  logic done_d, done_q;

  // Pulse on the same edge that writes P.
  always_comb begin
    done_d = last_iter && !load;
  end

  // Done register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult (6x6 defaults). Driver pushes expected P
// values with the cycle they must be visible; monitor checks at each negedge.
module tb_booth_mult;

  localparam int unsigned AW = 6;
  localparam int unsigned BW = 6;
  localparam int unsigned PW = AW + BW;

  logic          clk;
  logic          rst;
  logic          load;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic [PW-1:0] P;
`ifdef BOOTH_MULT_DONE_EN
  logic          done;
`endif

  booth_mult #(
    .A_WIDTH(AW),
    .B_WIDTH(BW),
    .P_WIDTH(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .load(load),
    .A   (A),
    .B   (B),
    .P   (P)
`ifdef BOOTH_MULT_DONE_EN
    ,
    .done(done)
`endif
  );

  typedef struct {
    logic [PW-1:0] p;
    int            due;
    logic          d;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;
  logic mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [PW-1:0] sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = sa * sb;
    return r;
  endfunction

  task automatic push(input logic [PW-1:0] p, input int due, input logic d);
    exp_t e;
    e.p   = p;
    e.due = due;
    e.d   = d;
    sb_q.push_back(e);
  endtask

  // Normal operation: result at load+4 negedges, then held for two more.
  task automatic op(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [PW-1:0] exp);
    A    = a;
    B    = b;
    load = 1'b1;
    push(exp, cyc + 4, 1'b1);
    push(exp, cyc + 5, 1'b0);
    push(exp, cyc + 6, 1'b0);
    @(negedge clk);
    load = 1'b0;
    A    = ~a;
    B    = ~b;
    repeat (6) @(negedge clk);
  endtask

  // Monitor: compare P (and done when present) whenever an entry falls due.
  always @(negedge clk) begin
    exp_t e;
    logic hit;
    if (mon_en) begin
      hit = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_check due=%0d now=%0d required P=%h", e.due, cyc, e.p);
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e   = sb_q.pop_front();
        hit = 1'b1;
        total++;
        if (P !== e.p) begin
          bad++;
          $display("FAIL p_check cyc=%0d got=%h required=%h", cyc, P, e.p);
        end
`ifdef BOOTH_MULT_DONE_EN
        total++;
        if (done !== e.d) begin
          bad++;
          $display("FAIL done_check cyc=%0d got=%b required=%b", cyc, done, e.d);
        end
`endif
      end
`ifdef BOOTH_MULT_DONE_EN
      if (!hit) begin
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL done_idle cyc=%0d got=%b required=0", cyc, done);
        end
      end
`endif
    end
  end

  initial begin
    int            c0;
    logic [31:0]   wa, wb;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    rst  = 1'b1;
    load = 1'b0;
    A    = '0;
    B    = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    rst    = 1'b0;
    push('0, cyc + 1, 1'b0);
    push('0, cyc + 2, 1'b0);
    repeat (3) @(negedge clk);

    // Directed products.
    op(6'd15, 6'd9, 12'h087);
    op(6'b100000, 6'b100000, 12'h400);
    op(6'h3F, 6'h1F, 12'hFE1);
    wa = 32'd2000;
    wb = 32'd128;
    op(wa[AW-1:0], wb[BW-1:0], 12'h000);
    op(6'h3F, 6'h3F, 12'h001);
    op(6'h1F, 6'b100000, 12'hC20);

    // Sweep against the signed reference.
    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom);
      rb = BW'($urandom);
      op(ra, rb, ref_prod(ra, rb));
    end

    // Reset on the second iteration edge: P drops to 0 and stays there.
    op(6'd5, 6'd5, 12'h019);
    c0   = cyc;
    A    = 6'd15;
    B    = 6'd9;
    load = 1'b1;
    push(12'h019, c0 + 1, 1'b0);
    push(12'h019, c0 + 2, 1'b0);
    for (int k = 3; k <= 7; k++) push('0, c0 + k, 1'b0);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Back-to-back load aborts the first operation.
    c0   = cyc;
    A    = 6'd15;
    B    = 6'd9;
    load = 1'b1;
    for (int k = 1; k <= 4; k++) push('0, c0 + k, 1'b0);
    push(12'hFF1, c0 + 5, 1'b1);
    push(12'hFF1, c0 + 6, 1'b0);
    @(negedge clk);
    A = 6'h3D;
    B = 6'd5;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);

    // Load coinciding with the final iteration: load wins, 49 never appears.
    c0   = cyc;
    A    = 6'd7;
    B    = 6'd7;
    load = 1'b1;
    for (int k = 1; k <= 6; k++) push(12'hFF1, c0 + k, 1'b0);
    push(12'hFFA, c0 + 7, 1'b1);
    push(12'hFFA, c0 + 8, 1'b0);
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    A    = 6'd2;
    B    = 6'h3D;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);

    for (int k = 0; k < 50 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
